// File: rtl/ipsxe_fft_drm_rd_streamer_if.sv
// ---------------------------------------------------------------------------
// ipsxe_fft_drm_rd_streamer_if
// Bundles the SDPRAM read port and the outgoing valid/ready word stream of
// the FFT data-RAM read streamer.
//   ram_rd_addr    streamer -> RAM     read address
//   ram_rd_clk_en  streamer -> RAM     read clock enable
//   ram_rd_oce     streamer -> RAM     output register enable
//   ram_rd_data    RAM -> streamer     read data (2 cycles after address)
//   m_data         streamer -> sink    stream word
//   m_valid        streamer -> sink    stream valid
//   m_last         streamer -> sink    last word of frame
//   m_ready        sink -> streamer    stream ready
// Modport master is the streamer view, slave is the RAM/sink view.
// ---------------------------------------------------------------------------
interface ipsxe_fft_drm_rd_streamer_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 36
);
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic                  ram_rd_clk_en;
    logic                  ram_rd_oce;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output ram_rd_addr, ram_rd_clk_en, ram_rd_oce, m_data, m_valid, m_last,
        input  ram_rd_data, m_ready
    );

    modport slave (
        input  ram_rd_addr, ram_rd_clk_en, ram_rd_oce, m_data, m_valid, m_last,
        output ram_rd_data, m_ready
    );
endinterface

// File: rtl/ipsxe_fft_drm_rd_streamer.sv
// ---------------------------------------------------------------------------
// ipsxe_fft_drm_rd_streamer
// Reads one frame of 2^ADDR_WIDTH words from the FFT result SDPRAM (natural
// or bit-reversed order) and presents it as a valid/ready stream with a
// last flag. A 4-entry credit-controlled FIFO absorbs the RAM read latency
// so sink backpressure never loses or repeats a word.
// Ports:
//   rd_clk   in   clock, rising edge
//   rd_rst   in   synchronous active-high reset
//   start    in   frame start pulse, honoured only when idle
//   bit_rev  in   address order, captured with start (1 = bit-reversed)
//   busy     out  high from accepted start until done
//   done     out  one-cycle pulse after the last word is accepted
//   bus      master modport: RAM read port + output stream
// ---------------------------------------------------------------------------
module ipsxe_fft_drm_rd_streamer #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 36,
    parameter int FIFO_DEPTH = 4
) (
    input  logic rd_clk,
    input  logic rd_rst,
    input  logic start,
    input  logic bit_rev,
    output logic busy,
    output logic done,
    ipsxe_fft_drm_rd_streamer_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0]  LP_N     = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]  LP_LAST  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [PTR_W+1:0]     LP_DEPTH = (PTR_W+2)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]       LP_FULL  = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic                  r_rev;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_en;
    logic                  r_busy;
    logic                  r_done;

    // two-stage tag pipe matching the RAM read latency
    logic                  r_v1, r_v2;
    logic                  r_l1, r_l2;

    // output FIFO; bit DATA_WIDTH of each entry is the last flag
    logic [DATA_WIDTH:0]   r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wp, r_rp;
    logic [PTR_W:0]        r_fifo_cnt;

    logic                  w_valid;
    logic                  w_pop;
    logic                  w_push;
    logic [PTR_W+1:0]      w_used;
    logic                  w_issue;
    logic                  w_issue_last;
    logic [DATA_WIDTH:0]   w_head;

    function automatic logic [ADDR_WIDTH-1:0] f_bitrev(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
        return r;
    endfunction

    assign w_valid = (r_fifo_cnt != '0);
    assign w_pop   = w_valid && bus.m_ready;
    assign w_push  = r_v2;
    assign w_head  = r_fifo[r_rp];

    // Credits: words already queued plus words still inside the RAM pipe,
    // less the word leaving this cycle, must leave room for one more.
    assign w_used  = {1'b0, r_fifo_cnt}
                   + {{(PTR_W+1){1'b0}}, r_v1}
                   + {{(PTR_W+1){1'b0}}, r_v2}
                   - {{(PTR_W+1){1'b0}}, w_pop};

    assign w_issue      = (r_state == S_READ) && (r_cnt < LP_N) && (w_used < LP_DEPTH);
    assign w_issue_last = (r_cnt == LP_LAST);

    assign bus.ram_rd_addr   = r_addr;
    assign bus.ram_rd_clk_en = r_en;
    assign bus.ram_rd_oce    = r_en;
    // Storage is not reset, so gate the head with valid to keep outputs 0 when empty.
    assign bus.m_valid       = w_valid;
    assign bus.m_data        = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign bus.m_last        = w_valid & w_head[DATA_WIDTH];
    assign busy              = r_busy;
    assign done              = r_done;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rev   <= 1'b0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_READ;
                        r_rev   <= bit_rev;
                        r_cnt   <= '0;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_issue) begin
                        r_addr <= r_rev ? f_bitrev(r_cnt[ADDR_WIDTH-1:0]) : r_cnt[ADDR_WIDTH-1:0];
                        r_cnt  <= r_cnt + (ADDR_WIDTH+1)'(1);
                        if (w_issue_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The last-tagged word is the final one issued, so its
                    // acceptance implies an empty pipe and FIFO. State stays
                    // DRAIN during the done cycle so a start there is ignored.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_en    <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_pop && w_head[DATA_WIDTH]) begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_wp       <= '0;
            r_rp       <= '0;
            r_fifo_cnt <= '0;
        end else begin
            r_v1 <= w_issue;
            r_v2 <= r_v1;
            if (w_push) r_wp <= r_wp + PTR_W'(1);
            if (w_pop)  r_rp <= r_rp + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + (PTR_W+1)'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - (PTR_W+1)'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge rd_clk) begin
        r_l1 <= w_issue_last;
        r_l2 <= r_l1;
        if (w_push) r_fifo[r_wp] <= {r_l2, bus.ram_rd_data};
    end

    always @(posedge rd_clk) begin
        if (!rd_rst) begin
            a_no_overflow: assert (!(w_push && !w_pop && r_fifo_cnt == LP_FULL));
        end
    end
endmodule

// File: tb/tb_ipsxe_fft_drm_rd_streamer.sv
module tb_ipsxe_fft_drm_rd_streamer;
    localparam int AW = 3;
    localparam int DW = 36;
    localparam int N  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, bit_rev, busy, done;
    logic [DW-1:0] mem [N];
    logic [DW-1:0] r_rdq;

    int n_cmp = 0;
    int n_bad = 0;

    ipsxe_fft_drm_rd_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ipsxe_fft_drm_rd_streamer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .rd_clk  (clk),
        .rd_rst  (rst),
        .start   (start),
        .bit_rev (bit_rev),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    // RAM model: address registered by the DUT, data returned one edge later,
    // so data is sampled two edges after the address issue edge.
    always_ff @(posedge clk) begin
        if (bus.ram_rd_clk_en && bus.ram_rd_oce) r_rdq <= mem[bus.ram_rd_addr];
    end
    assign bus.ram_rd_data = r_rdq;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] exp_word(input bit rev, input int k);
        int idx;
        idx = rev ? (((k & 1) << 2) | (k & 2) | ((k >> 2) & 1)) : k;
        return 36'h100 + DW'(idx);
    endfunction

    task automatic chk_zero(input string p);
        chk({p, "_addr"},  64'(bus.ram_rd_addr), 0);
        chk({p, "_clken"}, 64'(bus.ram_rd_clk_en), 0);
        chk({p, "_oce"},   64'(bus.ram_rd_oce), 0);
        chk({p, "_data"},  64'(bus.m_data), 0);
        chk({p, "_valid"}, 64'(bus.m_valid), 0);
        chk({p, "_last"},  64'(bus.m_last), 0);
        chk({p, "_busy"},  64'(busy), 0);
        chk({p, "_done"},  64'(done), 0);
    endtask

    // mode 0: ready always 1; mode 1: random ready with 10-cycle stall after word 2
    task automatic run_frame(input bit rev, input int mode, input int restart_at, input bit start_on_done);
        int k, cyc, first_v, done_cyc, stall_left, quiet;
        logic r, hold, hold_last;
        logic [DW-1:0] hold_data;
        k = 0; cyc = 0; first_v = -1; done_cyc = -1; hold = 1'b0;
        hold_last = 1'b0; hold_data = '0;
        stall_left = (mode == 1) ? 10 : 0;
        chk("busy_idle", 64'(busy), 0);
        start = 1'b1; bit_rev = rev;
        tick();
        start = 1'b0; bit_rev = 1'b0;
        chk("busy_up", 64'(busy), 1);
        while (done_cyc < 0 && cyc < 400) begin
            if (mode == 0) r = 1'b1;
            else if (k == 3 && stall_left > 0) begin r = 1'b0; stall_left--; end
            else r = 1'($urandom_range(0, 1));
            bus.m_ready = r;
            start = (cyc == restart_at);
            if (hold) begin
                chk("hold_data", 64'(bus.m_data), 64'(hold_data));
                chk("hold_last", 64'(bus.m_last), 64'(hold_last));
            end
            if (bus.m_valid && first_v < 0) first_v = cyc;
            if (bus.m_valid && r) begin
                chk("word", 64'(bus.m_data), 64'(exp_word(rev, k)));
                chk("last", 64'(bus.m_last), 64'(k == N-1));
                if (mode == 0) chk("word_cyc", 64'(cyc), 64'(3 + k));
                k++;
            end
            hold = bus.m_valid && !r;
            hold_data = bus.m_data;
            hold_last = bus.m_last;
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", 64'(busy), 0);
                chk("words_at_done", 64'(k), N);
                if (start_on_done) start = 1'b1;
            end
            tick();
            cyc++;
        end
        chk("done_seen", 64'(done_cyc >= 0), 1);
        chk("words", 64'(k), N);
        if (mode == 0) begin
            chk("first_valid_cyc", 64'(first_v), 3);
            chk("done_cyc", 64'(done_cyc), 3 + N);
        end
        bus.m_ready = 1'b1;
        if (start_on_done) begin
            chk("start_on_done_ignored", 64'(busy), 0);
            chk("done_one_cycle", 64'(done), 0);
        end else begin
            start = 1'b0;
            quiet = 0;
            for (int i = 0; i < 8; i++) begin
                if (bus.m_valid || busy || done) quiet++;
                tick();
            end
            chk("quiet_after_frame", 64'(quiet), 0);
        end
    endtask

    initial begin
        int k, quiet;
        for (int i = 0; i < N; i++) mem[i] = 36'h100 + DW'(i);
        rst = 1'b1; start = 1'b0; bit_rev = 1'b0; bus.m_ready = 1'b1;
        @(negedge clk);
        repeat (3) tick();
        chk_zero("rst");
        rst = 1'b0;
        tick();

        run_frame(1'b0, 0, -1, 1'b0);
        run_frame(1'b1, 0, -1, 1'b0);
        run_frame(1'b0, 1, -1, 1'b0);
        run_frame(1'b0, 0, 4, 1'b0);

        // abort a frame with reset right after word 3 is accepted
        k = 0;
        start = 1'b1; bit_rev = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 50 && k < 4; i++) begin
            if (bus.m_valid && bus.m_ready) k++;
            tick();
        end
        chk("pre_rst_words", 64'(k), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.m_valid || busy || done) quiet++;
            tick();
        end
        chk("quiet_after_rst", 64'(quiet), 0);
        run_frame(1'b0, 0, -1, 1'b0);

        // start on the done cycle is ignored; one cycle later it is taken
        run_frame(1'b0, 0, -1, 1'b1);
        run_frame(1'b1, 0, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ipsxe_fft_drm_rd_streamer.md
Name: ipsxe_fft_drm_rd_streamer

Overview:
- Read-side controller for the FFT data-RAM SDPRAM. It runs on the read port configured with output register on, read clock enable and OCE enabled, giving a fixed 2-cycle address-to-data latency.
- On a start pulse it reads one full frame of 2^ADDR_WIDTH words, in natural or bit-reversed address order. It presents the words as a valid/ready stream with a last flag.
- A 4-entry credit-controlled output FIFO absorbs the RAM pipeline, so downstream backpressure never drops or duplicates a word.
- It sits between the FFT result RAM and the output/unload interface.

Parameters:
- ADDR_WIDTH, 9, RAM read address width; frame length N = 2^ADDR_WIDTH.
- DATA_WIDTH, 36, RAM read data width and stream width.
- FIFO_DEPTH, 4, output FIFO depth; fixed at 4, must be ≥ RAM latency + 2.

Ports:
- rd_clk  in  1  clock; all logic on rising edge.
- rd_rst  in  1  reset, synchronous, active-high.
- start  in  1  frame start pulse; accepted only in IDLE.
- bit_rev  in  1  address order select, sampled with accepted start: 1 = bit-reversed.
- ram_rd_addr  out  ADDR_WIDTH  SDPRAM read address.
- ram_rd_clk_en  out  1  SDPRAM read clock enable.
- ram_rd_oce  out  1  SDPRAM output register enable.
- ram_rd_data  in  DATA_WIDTH  SDPRAM read data, valid 2 cycles after its address.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  marks word N-1 of the frame.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rd_rst=1 at an edge) clears everything regardless of state: state=IDLE, counters=0, in-flight pipe cleared, FIFO flushed. All outputs return to 0 (ram_rd_addr, ram_rd_clk_en, ram_rd_oce, m_data, m_valid, m_last, busy, done). Reset mid-frame abandons the frame; no done pulse.
- States:
  - IDLE: waits for start; busy=0.
  - READ: issues addresses.
  - DRAIN: all N addresses issued; waits for in-flight words and the FIFO to empty.
- IDLE->READ: on start=1. Capture bit_rev, clear issue counter cnt, busy=1 from the next cycle. start in READ/DRAIN is ignored.
- Issue rule (READ):
  - An address is issued in a cycle when cnt<N and fifo_count + inflight + (FIFO pop this cycle ? -1 : 0) < FIFO_DEPTH.
  - ram_rd_addr = bit_rev_q ? bit-reverse(cnt[ADDR_WIDTH-1:0]) : cnt; then cnt increments.
  - ram_rd_addr holds its last value on non-issue cycles.
- inflight: a 2-stage valid shift register tagging issued addresses. Stage 2 valid means ram_rd_data is pushed into the FIFO that cycle.
  - A tag bit marks cnt==N-1 and travels with the word as m_last.
- READ->DRAIN: the cycle the address for cnt=N-1 is issued.
- DRAIN->IDLE: when inflight==0, the FIFO is empty, and the final (m_last) word has been accepted. done=1 for exactly that one cycle; busy=0 from the same cycle.
- ram_rd_clk_en and ram_rd_oce are both 1 whenever state≠IDLE, otherwise 0. They stay high through DRAIN so in-flight data completes.
- FIFO:
  - First-word-fall-through: m_valid = (fifo_count≠0); m_data/m_last show the head entry.
  - Pop occurs when m_valid && m_ready.
  - Simultaneous push and pop in one cycle leaves the count unchanged; the pushed word is ordered after the head.
  - Credit rule guarantees a push never hits a full FIFO. Overflow is illegal and must be asserted in simulation.
  - While m_valid=1 and m_ready=0, m_data/m_last are stable.
- Latency: with m_ready held at 1, first m_valid appears 3 cycles after the start edge (issue at cycle 1, data at cycle 3). Throughput is 1 word/cycle sustained. A frame of N words completes with done 3+N cycles after start.
- Bit-reverse for ADDR_WIDTH=3: order 0,4,2,6,1,5,3,7.

Test Plan:
- ADDR_WIDTH=3, RAM preloaded word[i]=i+0x100, bit_rev=0, m_ready=1 -> m_data 0x100..0x107 on consecutive cycles; m_last only on 0x107; done one cycle after; busy 0->1->0.
- Same preload, bit_rev=1 -> m_data order 0x100,0x104,0x102,0x106,0x101,0x105,0x103,0x107; m_last on 0x107.
- m_ready toggling randomly (50%), plus a 10-cycle stall after word 2 -> all 8 words in order, no loss or duplication; fifo_count never exceeds 4; issue stalls while credits are exhausted.
- start pulsed again mid-frame (cycle 4) -> ignored; exactly one frame of 8 words and one done pulse.
- rd_rst asserted for 1 cycle after word 3 accepted -> next cycle all outputs 0, state IDLE, no done; a new start then yields a full fresh frame from word 0.
- start asserted on the same cycle as done -> not accepted (state not yet IDLE); start one cycle later -> accepted, second frame begins with first m_valid 3 cycles later.
